// File: rtl/conv_window_engine_if.sv
// Stream bundle for conv_window_engine: coefficient load, pixel in, result out, status.
interface conv_window_engine_if #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 16
);
   logic signed [COEF_W-1:0] coef_in;
   logic                     coef_in_valid;
   logic                     coef_in_ready;
   logic [DATA_W-1:0]        pix_in;
   logic                     pix_in_valid;
   logic                     pix_in_ready;
   logic signed [OUT_W-1:0]  pix_out;
   logic                     pix_out_valid;
   logic                     pix_out_ready;
   logic                     frame_done;
   logic                     busy;

   modport master (
      output coef_in, coef_in_valid, pix_in, pix_in_valid, pix_out_ready,
      input  coef_in_ready, pix_in_ready, pix_out, pix_out_valid, frame_done, busy
   );
   modport slave (
      input  coef_in, coef_in_valid, pix_in, pix_in_valid, pix_out_ready,
      output coef_in_ready, pix_in_ready, pix_out, pix_out_valid, frame_done, busy
   );
endinterface

// File: rtl/conv_window_engine.sv
// K x K streaming convolution over raster pixels with a runtime-loadable signed kernel.
// Optional CONV_WINDOW_ABS_EN: emit |shifted sum| before saturation (edge magnitude).
module conv_window_engine #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 16,
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512,
   parameter int K      = 3,
   parameter int SHIFT  = 0
) (
   input logic               clk,
   input logic               rst_n,
   conv_window_engine_if.slave bus
);
   localparam int NK     = K * K;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int SUM_W  = DATA_W + COEF_W + $clog2(NK) + 1;
   localparam int KW     = $clog2(NK);
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW     = $clog2(NPIX + 1);
   localparam int STAGES = 2;
   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {LOAD, RUN, FLUSH} state_t;

   state_t                   state_q, state_d;
   logic [KW-1:0]            coef_cnt;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic [PW-1:0]            pix_cnt;
   logic signed [COEF_W-1:0] coef_q [NK];
   logic [DATA_W-1:0]        lb [K-1][IMG_W];
   logic [DATA_W-1:0]        win [K][K];
   logic [DATA_W-1:0]        new_col [K];
   logic signed [PROD_W-1:0] prod [NK];
   logic [STAGES:0]          vld_pipe;
   logic signed [OUT_W-1:0]  out_q;
   logic                     frame_done_q;
   logic signed [SUM_W-1:0]  sum, shifted, mag;
   logic signed [OUT_W-1:0]  sat_val;
   logic                     coef_rdy, pix_rdy, coef_fire, pix_fire, win_fire;
   logic                     stall, last_pix, last_res;

   // Any unaccepted result freezes every stage, so pix_out stays put.
   assign stall     = vld_pipe[STAGES] && !bus.pix_out_ready;
   assign last_pix  = (pix_cnt == PW'(NPIX - 1));
   assign last_res  = (state_q == FLUSH) && vld_pipe[STAGES] && bus.pix_out_ready
                      && !(|vld_pipe[STAGES-1:0]);
   assign coef_fire = coef_rdy && bus.coef_in_valid;
   assign pix_fire  = pix_rdy && bus.pix_in_valid;
   assign win_fire  = pix_fire && (row >= RW'(K - 1)) && (col >= CW'(K - 1));

   always_comb begin
      state_d  = state_q;
      coef_rdy = 1'b0;
      pix_rdy  = 1'b0;
      case (state_q)
         LOAD: begin
            coef_rdy = 1'b1;
            if (bus.coef_in_valid && coef_cnt == KW'(NK - 1)) state_d = RUN;
         end
         RUN: begin
            // A reload beat at a frame boundary takes priority over the first pixel.
            coef_rdy = (pix_cnt == '0);
            pix_rdy  = !stall && (pix_cnt < PW'(NPIX)) && !(coef_rdy && bus.coef_in_valid);
            if (coef_rdy && bus.coef_in_valid)              state_d = LOAD;
            else if (pix_rdy && bus.pix_in_valid && last_pix) state_d = FLUSH;
         end
         FLUSH: if (last_res) state_d = RUN;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LOAD;
         coef_cnt     <= '0;
         col          <= '0;
         row          <= '0;
         pix_cnt      <= '0;
         vld_pipe     <= '0;
         out_q        <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < NK; i++) coef_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= last_res;
         if (coef_fire) begin
            coef_q[coef_cnt] <= bus.coef_in;
            coef_cnt         <= (coef_cnt == KW'(NK - 1)) ? '0 : coef_cnt + 1'b1;
         end
         if (last_res) begin
            pix_cnt <= '0;
            col     <= '0;
            row     <= '0;
         end else if (pix_fire) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], win_fire};
            if (vld_pipe[STAGES-1]) out_q <= sat_val;
         end
      end
   end

   // Line buffer j holds line row-(K-1-j); the new window column is read at col.
   always_comb begin
      for (int j = 0; j < K - 1; j++) new_col[j] = lb[j][col];
      new_col[K-1] = bus.pix_in;
   end

   // Line buffers, window and products need no reset: validity rides on vld_pipe.
   always_ff @(posedge clk) begin
      if (pix_fire) begin
         for (int j = 0; j < K - 2; j++) lb[j][col] <= lb[j+1][col];
         lb[K-2][col] <= bus.pix_in;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
            win[r][K-1] <= new_col[r];
         end
      end
      if (!stall && vld_pipe[0]) begin
         for (int i = 0; i < NK; i++)
            prod[i] <= PROD_W'(signed'({1'b0, win[i/K][i%K]})) * PROD_W'(coef_q[i]);
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < NK; i++)
         sum = sum + {{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
      shifted = sum >>> SHIFT;
`ifdef CONV_WINDOW_ABS_EN
      mag = shifted[SUM_W-1] ? -shifted : shifted;
`else
      mag = shifted;
`endif
      if (mag > SAT_MAX)      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      else if (mag < SAT_MIN) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      else                    sat_val = mag[OUT_W-1:0];
   end

   assign bus.coef_in_ready = coef_rdy;
   assign bus.pix_in_ready  = pix_rdy;
   assign bus.pix_out       = out_q;
   assign bus.pix_out_valid = vld_pipe[STAGES];
   assign bus.frame_done    = frame_done_q;
   assign bus.busy          = frame_done_q || (pix_cnt != '0);
endmodule
